// File: rtl/axi_stride_master_if.sv
// AXI read address / read data channel bundle between the stride master and the
// downstream slave (prefetcher slave port).
interface axi_stride_master_if #(
    parameter int ADDR_BITS       = 32,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int TID_WIDTH       = 8,
    parameter int DATA_WIDTH      = 8
);
    logic                       m_ar_valid;
    logic                       m_ar_ready;
    logic [ADDR_BITS-1:0]       m_ar_addr;
    logic [BURST_LEN_WIDTH-1:0] m_ar_len;
    logic [TID_WIDTH-1:0]       m_ar_id;
    logic                       m_r_valid;
    logic                       m_r_ready;
    logic [DATA_WIDTH-1:0]      m_r_data;
    logic                       m_r_last;
    logic [TID_WIDTH-1:0]       m_r_id;

    modport master (
        output m_ar_valid, m_ar_addr, m_ar_len, m_ar_id, m_r_ready,
        input  m_ar_ready, m_r_valid, m_r_data, m_r_last, m_r_id
    );

    modport slave (
        input  m_ar_valid, m_ar_addr, m_ar_len, m_ar_id, m_r_ready,
        output m_ar_ready, m_r_valid, m_r_data, m_r_last, m_r_id
    );
endinterface

// File: rtl/axi_stride_master.sv
// Strided AXI read burst generator with bounded outstanding bursts, response
// checking (id / last / unsolicited beats) and an XOR checksum of returned data.
module axi_stride_master #(
    parameter int ADDR_BITS           = 32,
    parameter int BURST_LEN_WIDTH     = 8,
    parameter int TID_WIDTH           = 8,
    parameter int DATA_WIDTH          = 8,
    parameter int LOG_MAX_OUTSTANDING = 2,
    parameter int REQ_CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ADDR_BITS-1:0]       cfg_base,
    input  logic [ADDR_BITS-1:0]       cfg_stride,
    input  logic [REQ_CNT_WIDTH-1:0]   cfg_num_reqs,
    input  logic [BURST_LEN_WIDTH-1:0] cfg_len,
    input  logic [TID_WIDTH-1:0]       cfg_id,
    axi_stride_master_if.master        bus,
    output logic                       busy,
    output logic                       done,
    output logic [2:0]                 err,
    output logic [DATA_WIDTH-1:0]      checksum,
    output logic [REQ_CNT_WIDTH-1:0]   issued_cnt,
    output logic [REQ_CNT_WIDTH-1:0]   completed_cnt
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    localparam int OUT_W = LOG_MAX_OUTSTANDING + 1;
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(1) << LOG_MAX_OUTSTANDING;

    state_t                     state_r, state_s;
    logic [ADDR_BITS-1:0]       stride_r, stride_s;
    logic [REQ_CNT_WIDTH-1:0]   num_reqs_r, num_reqs_s;
    logic [BURST_LEN_WIDTH-1:0] len_r, len_s;
    logic [TID_WIDTH-1:0]       id_r, id_s;
    logic                       ar_valid_r, ar_valid_s;
    logic [ADDR_BITS-1:0]       ar_addr_r, ar_addr_s;
    logic [OUT_W-1:0]           outstanding_r, outstanding_s;
    logic [BURST_LEN_WIDTH-1:0] beat_idx_r, beat_idx_s;
    logic [REQ_CNT_WIDTH-1:0]   issued_r, issued_s;
    logic [REQ_CNT_WIDTH-1:0]   completed_r, completed_s;
    logic [2:0]                 err_r, err_s;
    logic [DATA_WIDTH-1:0]      checksum_r, checksum_s;
    logic                       busy_r, busy_s;
    logic                       done_r, done_s;
    logic                       r_ready_r, r_ready_s;
    logic                       ar_hs_s, r_hs_s, at_len_s, out_inc_s, out_dec_s;

    // Next-state and next-output computation for the run FSM and datapath.
    always_comb begin
        state_s       = state_r;
        stride_s      = stride_r;
        num_reqs_s    = num_reqs_r;
        len_s         = len_r;
        id_s          = id_r;
        ar_addr_s     = ar_addr_r;
        outstanding_s = outstanding_r;
        beat_idx_s    = beat_idx_r;
        issued_s      = issued_r;
        completed_s   = completed_r;
        err_s         = err_r;
        checksum_s    = checksum_r;
        out_inc_s     = 1'b0;
        out_dec_s     = 1'b0;
        at_len_s      = (beat_idx_r == len_r);
        ar_hs_s       = ar_valid_r & bus.m_ar_ready;
        r_hs_s        = r_ready_r & bus.m_r_valid;

        case (state_r)
            IDLE: begin
                if (start) begin
                    stride_s      = cfg_stride;
                    num_reqs_s    = cfg_num_reqs;
                    len_s         = cfg_len;
                    id_s          = cfg_id;
                    ar_addr_s     = cfg_base;
                    outstanding_s = '0;
                    beat_idx_s    = '0;
                    issued_s      = '0;
                    completed_s   = '0;
                    err_s         = 3'b000;
                    checksum_s    = '0;
                    if (cfg_num_reqs == '0) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = ISSUE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE, DRAIN: begin
                out_inc_s = (state_r == ISSUE) && ar_hs_s;
                if (r_hs_s) begin
                    checksum_s = checksum_r ^ bus.m_r_data;
                    if (bus.m_r_id != id_r) begin
                        err_s[0] = 1'b1;
                    end else begin
                        err_s[0] = err_r[0];
                    end
                    // A beat with nothing outstanding is flagged and XORed, but
                    // must not disturb the burst bookkeeping.
                    if (outstanding_r == '0) begin
                        err_s[2] = 1'b1;
                    end else if (at_len_s || bus.m_r_last) begin
                        err_s[1]    = err_r[1] | (at_len_s != bus.m_r_last);
                        beat_idx_s  = '0;
                        completed_s = completed_r + REQ_CNT_WIDTH'(1);
                        out_dec_s   = 1'b1;
                    end else begin
                        beat_idx_s = beat_idx_r + BURST_LEN_WIDTH'(1);
                    end
                end else begin
                    checksum_s = checksum_r;
                end

                if (out_inc_s) begin
                    issued_s  = issued_r + REQ_CNT_WIDTH'(1);
                    ar_addr_s = ar_addr_r + stride_r;
                end else begin
                    issued_s  = issued_r;
                end

                if (out_inc_s && !out_dec_s) begin
                    outstanding_s = outstanding_r + OUT_W'(1);
                end else if (!out_inc_s && out_dec_s) begin
                    outstanding_s = outstanding_r - OUT_W'(1);
                end else begin
                    outstanding_s = outstanding_r;
                end

                if (state_r == ISSUE) begin
                    if (out_inc_s && (issued_s == num_reqs_r)) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = ISSUE;
                    end
                end else if (outstanding_s == '0) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the next state.
        ar_valid_s = (state_s == ISSUE) && (outstanding_s < MAX_OUT);
        busy_s     = (state_s == ISSUE) || (state_s == DRAIN);
        r_ready_s  = busy_s;
        done_s     = (state_s == DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            stride_r      <= '0;
            num_reqs_r    <= '0;
            len_r         <= '0;
            id_r          <= '0;
            ar_valid_r    <= 1'b0;
            ar_addr_r     <= '0;
            outstanding_r <= '0;
            beat_idx_r    <= '0;
            issued_r      <= '0;
            completed_r   <= '0;
            err_r         <= 3'b000;
            checksum_r    <= '0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            r_ready_r     <= 1'b0;
        end else begin
            state_r       <= state_s;
            stride_r      <= stride_s;
            num_reqs_r    <= num_reqs_s;
            len_r         <= len_s;
            id_r          <= id_s;
            ar_valid_r    <= ar_valid_s;
            ar_addr_r     <= ar_addr_s;
            outstanding_r <= outstanding_s;
            beat_idx_r    <= beat_idx_s;
            issued_r      <= issued_s;
            completed_r   <= completed_s;
            err_r         <= err_s;
            checksum_r    <= checksum_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
            r_ready_r     <= r_ready_s;
        end
    end

    assign bus.m_ar_valid = ar_valid_r;
    assign bus.m_ar_addr  = ar_addr_r;
    assign bus.m_ar_len   = len_r;
    assign bus.m_ar_id    = id_r;
    assign bus.m_r_ready  = r_ready_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign err            = err_r;
    assign checksum       = checksum_r;
    assign issued_cnt     = issued_r;
    assign completed_cnt  = completed_r;
endmodule
